// File: rtl/max7219_ctrlmod.sv
// max7219_ctrlmod: command sequencer in front of the MAX7219 SPI write module.
// Runs the init command list after reset, then refreshes the eight digit
// registers from a local 8x8 frame buffer whenever a refresh is requested.
module max7219_ctrlmod #(
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter logic [2:0] SCAN_LIMIT     = 3'd7,
  parameter bit         AUTO_REFRESH   = 1'b1
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       iWrEn,
  input  logic [2:0] iWrAddr,
  input  logic [7:0] iWrData,
  input  logic [3:0] iIntensity,
  input  logic       iRefresh,
  output logic       oCall,
  input  logic       iDone,
  output logic [7:0] oADDR,
  output logic [7:0] oDATA,
  output logic       oBusy,
  output logic       oReady
);

  localparam int unsigned ROWS      = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned INIT_LAST = 4;  // index of last init command
  localparam int unsigned REFR_LAST = 8;  // index of last refresh command

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REFR} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_CALL, PH_GAP} phase_t;

  logic [7:0]       frame [ROWS];
  state_t           state;
  phase_t           phase;
  logic [IDX_W-1:0] idx;
  logic             pending;

  logic [7:0]       cmd_addr_c;
  logic [7:0]       cmd_data_c;
  logic             last_cmd_c;
  logic [2:0]       row_sel_c;

  // Refresh command k (k >= 1) carries frame row k-1.
  assign row_sel_c = 3'(idx - IDX_W'(1));

  // Address/data pair and end-of-list flag for the current command index.
  always_comb begin
    cmd_addr_c = 8'h00;
    cmd_data_c = 8'h00;
    last_cmd_c = 1'b0;
    if (state == ST_INIT) begin
      last_cmd_c = (idx == IDX_W'(INIT_LAST));
      case (idx)
        IDX_W'(0): begin cmd_addr_c = 8'h09; cmd_data_c = 8'h00;                    end
        IDX_W'(1): begin cmd_addr_c = 8'h0A; cmd_data_c = {4'h0, INIT_INTENSITY};   end
        IDX_W'(2): begin cmd_addr_c = 8'h0B; cmd_data_c = {5'h00, SCAN_LIMIT};      end
        IDX_W'(3): begin cmd_addr_c = 8'h0C; cmd_data_c = 8'h01;                    end
        default:   begin cmd_addr_c = 8'h0F; cmd_data_c = 8'h00;                    end
      endcase
    end else begin
      last_cmd_c = (idx == IDX_W'(REFR_LAST));
      if (idx == IDX_W'(0)) begin
        cmd_addr_c = 8'h0A;
        cmd_data_c = {4'h0, iIntensity};
      end else begin
        cmd_addr_c = 8'(idx);
        cmd_data_c = frame[row_sel_c];
      end
    end
  end

  // Frame buffer: writable at any time; a same-cycle LOAD still sees the old row.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < ROWS; i++) frame[i] <= 8'h00;
    end else if (iWrEn) begin
      frame[iWrAddr] <= iWrData;
    end
  end

  // Sequencer: list selection, LOAD/CALL/GAP handshake, registered outputs.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= ST_INIT;
      phase   <= PH_LOAD;
      idx     <= '0;
      pending <= 1'b0;
      oCall   <= 1'b0;
      oADDR   <= 8'h00;
      oDATA   <= 8'h00;
      oBusy   <= 1'b0;
      oReady  <= 1'b0;
    end else begin
      // Requests arriving mid-list collapse into one pending refresh.
      if (iRefresh && (state != ST_IDLE)) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          oBusy <= 1'b0;
          if (iRefresh || pending) begin
            state   <= ST_REFR;
            phase   <= PH_LOAD;
            idx     <= '0;
            pending <= 1'b0;
            oBusy   <= 1'b1;
          end
        end

        default: begin
          oBusy <= 1'b1;
          case (phase)
            PH_LOAD: begin
              oADDR <= cmd_addr_c;
              oDATA <= cmd_data_c;
              oCall <= 1'b1;
              phase <= PH_CALL;
            end

            PH_CALL: begin
              if (iDone) begin
                oCall <= 1'b0;
                phase <= PH_GAP;
                if ((state == ST_INIT) && last_cmd_c) oReady <= 1'b1;
              end
            end

            default: begin
              // One idle cycle with oCall low so the write module re-arms.
              phase <= PH_LOAD;
              if (!last_cmd_c) begin
                idx <= idx + IDX_W'(1);
              end else if (pending || ((state == ST_INIT) && AUTO_REFRESH)) begin
                state   <= ST_REFR;
                idx     <= '0;
                pending <= 1'b0;
              end else begin
                state <= ST_IDLE;
                idx   <= '0;
                oBusy <= 1'b0;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
